// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: button, halt and CPU clock/reset signals of the clock sequencer.
// Optional speed select is present when CLK_SPEED_SEL_EN is defined.
interface clock_ctrl_if;
    logic       btn_step;
    logic       btn_run;
    logic       rst_req;
    logic       cpu_halt;
`ifdef CLK_SPEED_SEL_EN
    logic [1:0] speed;
`endif
    logic       cpu_ce;
    logic       cpu_reset;
    logic       running;
    logic       halted;

`ifdef CLK_SPEED_SEL_EN
    modport master (
        input  btn_step, btn_run, rst_req, cpu_halt, speed,
        output cpu_ce, cpu_reset, running, halted
    );
    modport slave (
        output btn_step, btn_run, rst_req, cpu_halt, speed,
        input  cpu_ce, cpu_reset, running, halted
    );
`else
    modport master (
        input  btn_step, btn_run, rst_req, cpu_halt,
        output cpu_ce, cpu_reset, running, halted
    );
    modport slave (
        output btn_step, btn_run, rst_req, cpu_halt,
        input  cpu_ce, cpu_reset, running, halted
    );
`endif
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: CPU clock sequencer (reset hold, stop, step, run, halt).
// Define CLK_SPEED_SEL_EN to add the speed[1:0] run-period select.
module clock_ctrl #(
    parameter int DIV_WIDTH = 16,
    parameter int RUN_DIV   = 50000,
    parameter int RST_HOLD  = 4
) (
    input  logic          clk,
    input  logic          reset,
    clock_ctrl_if.master  io
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);
    localparam logic [DIV_WIDTH-1:0] TDIV = DIV_WIDTH'(RUN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        S_RST,
        S_STOP,
        S_RUN,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ce_d;
    logic                 step_q, run_q;
    logic                 rise_step, rise_run;
    logic                 wrap;

    assign rise_step = io.btn_step & ~step_q;
    assign rise_run  = io.btn_run & ~run_q;

`ifdef CLK_SPEED_SEL_EN
    logic [DIV_WIDTH-1:0] per;
    logic [DIV_WIDTH-1:0] last;

    // Run period scales down by 4x per speed step, never below one cycle.
    always_comb begin
        per = TDIV >> {io.speed, 1'b0};
        if (per == '0) begin
            per = ONE;
        end
        last = per - ONE;
    end

    assign wrap = div_q >= last;
`else
    assign wrap = div_q == TDIV - ONE;
`endif

    // Button history; starts high so a button held through reset is no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b1;
            run_q  <= 1'b1;
        end else begin
            step_q <= io.btn_step;
            run_q  <= io.btn_run;
        end
    end

    // Next state: rst_req, then halt, then run edge, then step edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        if (io.rst_req) begin
            state_d = S_RST;
            hold_d  = '0;
            div_d   = '0;
        end else begin
            case (state_q)
                S_RST: begin
                    if (hold_q == HOLD_MAX) begin
                        state_d = S_STOP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (io.cpu_halt) begin
                        state_d = S_HALT;
                    end else if (rise_run) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end else if (rise_step) begin
                        ce_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (io.cpu_halt) begin
                        state_d = S_HALT;
                        div_d   = '0;
                    end else if (rise_run) begin
                        state_d = S_STOP;
                        div_d   = '0;
                    end else if (wrap) begin
                        ce_d  = 1'b1;
                        div_d = '0;
                    end else begin
                        div_d = div_q + ONE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_RST;
                    hold_d  = '0;
                    div_d   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RST;
            hold_q       <= '0;
            div_q        <= '0;
            io.cpu_ce    <= 1'b0;
            io.cpu_reset <= 1'b1;
            io.running   <= 1'b0;
            io.halted    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            div_q        <= div_d;
            io.cpu_ce    <= ce_d;
            io.cpu_reset <= state_d == S_RST;
            io.running   <= state_d == S_RUN;
            io.halted    <= state_d == S_HALT;
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: scoreboard bench for clock_ctrl against an edge-count model.
// Build with CLK_SPEED_SEL_EN defined to exercise the speed select.
module tb_clock_ctrl;

    localparam int HOLD = 3;
`ifdef CLK_SPEED_SEL_EN
    localparam int RDIV = 16;
`else
    localparam int RDIV = 4;
`endif
    localparam int M_RST  = 0;
    localparam int M_STOP = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    clock_ctrl_if bus();

    clock_ctrl #(
        .DIV_WIDTH(16),
        .RUN_DIV  (RDIV),
        .RST_HOLD (HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;

    typedef struct {
        int tag;
        bit [2:0] st;
    } stat_t;

    int    pq[$];
    stat_t sq[$];

    int mode = M_RST;
    int low = 0;
    int anchor = 0;
    bit ps = 1'b1;
    bit pr = 1'b1;
`ifdef CLK_SPEED_SEL_EN
    logic [1:0] spd = 2'd0;
`endif

    function automatic int period();
        int t;
        t = RDIV;
`ifdef CLK_SPEED_SEL_EN
        t = RDIV >> (2 * int'(spd));
        if (t < 1) t = 1;
`endif
        return t;
    endfunction

    function automatic bit due_next();
        return mode == M_RUN && (cyc + 1 - anchor) >= period();
    endfunction

    // Reference: predict outputs after the coming edge from current inputs.
    task automatic model_edge();
        int e;
        bit pulse;
        bit rs;
        bit rr;
        stat_t s;
        e = cyc + 1;
        pulse = 1'b0;
        rs = bus.btn_step && !ps;
        rr = bus.btn_run && !pr;
        ps = bus.btn_step;
        pr = bus.btn_run;
        if (bus.rst_req) begin
            mode = M_RST;
            low = 0;
        end else begin
            case (mode)
                M_RST: begin
                    low++;
                    if (low > HOLD) mode = M_STOP;
                end
                M_STOP: begin
                    if (bus.cpu_halt) mode = M_HALT;
                    else if (rr) begin
                        mode = M_RUN;
                        anchor = e;
                    end else if (rs) pulse = 1'b1;
                end
                M_RUN: begin
                    if (bus.cpu_halt) mode = M_HALT;
                    else if (rr) mode = M_STOP;
                    else if (e - anchor >= period()) begin
                        pulse = 1'b1;
                        anchor = e;
                    end
                end
                default: ;
            endcase
        end
        if (pulse) pq.push_back(e);
        s.tag = e;
        s.st = {mode == M_RST, mode == M_RUN, mode == M_HALT};
        sq.push_back(s);
    endtask

    task automatic drive(input bit s, input bit r, input bit q, input bit h);
        bus.btn_step = s;
        bus.btn_run  = r;
        bus.rst_req  = q;
        bus.cpu_halt = h;
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input bit s);
        #1 reset = 1'b1;
        bus.btn_step = s;
        bus.btn_run  = 1'b0;
        bus.rst_req  = 1'b0;
        bus.cpu_halt = 1'b0;
        mode = M_RST;
        low = 0;
        ps = 1'b1;
        pr = 1'b1;
        #1;
        checks++;
        if ({bus.cpu_reset, bus.cpu_ce, bus.running, bus.halted} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_values: got %b required 1000",
                     {bus.cpu_reset, bus.cpu_ce, bus.running, bus.halted});
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    stat_t mst;
    bit    mexp;

    // Monitor: pop and compare whatever the model predicted for this edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (sq.size() > 0 && sq[0].tag == cyc) begin
                mst = sq.pop_front();
                checks++;
                if ({bus.cpu_reset, bus.running, bus.halted} !== mst.st) begin
                    fails++;
                    $display("FAIL status @%0d: got rst/run/hlt=%b required %b",
                             cyc, {bus.cpu_reset, bus.running, bus.halted}, mst.st);
                end
            end
            mexp = pq.size() > 0 && pq[0] == cyc;
            if (mexp) void'(pq.pop_front());
            if (bus.cpu_ce || mexp) begin
                checks++;
                if (bus.cpu_ce !== mexp) begin
                    fails++;
                    $display("FAIL cpu_ce @%0d: got %b required %b",
                             cyc, bus.cpu_ce, mexp);
                end
            end
        end
    end

    initial begin
        bus.btn_step = 1'b0;
        bus.btn_run  = 1'b0;
        bus.rst_req  = 1'b0;
        bus.cpu_halt = 1'b0;
`ifdef CLK_SPEED_SEL_EN
        bus.speed = 2'd0;
`endif
        @(negedge clk);
        do_reset(3, 1'b0);
        repeat (10) drive(0, 0, 0, 0);

        repeat (10) drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        repeat (2) drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0);

        repeat (2) drive(0, 1, 0, 0);
        repeat (31) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (8) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0);

        for (int i = 0; i < 40 && !due_next(); i++) drive(0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        repeat (8) drive(0, 0, 0, 0);

        drive(0, 1, 1, 0);
        repeat (8) drive(0, 0, 0, 0);
        repeat (2) drive(1, 0, 0, 0);
        do_reset(2, 1'b1);
        repeat (10) drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0);

`ifdef CLK_SPEED_SEL_EN
        spd = 2'd0;
        bus.speed = spd;
        drive(0, 1, 0, 0);
        repeat (40) drive(0, 0, 0, 0);
        spd = 2'd1;
        bus.speed = spd;
        repeat (20) drive(0, 0, 0, 0);
        spd = 2'd2;
        bus.speed = spd;
        repeat (10) drive(0, 0, 0, 0);
        spd = 2'd0;
        bus.speed = spd;
        for (int i = 0; i < 40 && (cyc + 1 - anchor) != 11; i++) drive(0, 0, 0, 0);
        spd = 2'd2;
        bus.speed = spd;
        repeat (5) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit r;
            s = bus.btn_step;
            r = bus.btn_run;
            if ($urandom_range(0, 3) == 0) s = !s;
            if ($urandom_range(0, 19) == 0) r = !r;
`ifdef CLK_SPEED_SEL_EN
            if ($urandom_range(0, 29) == 0) begin
                spd = 2'($urandom_range(0, 3));
                bus.speed = spd;
            end
`endif
            if ($urandom_range(0, 599) == 0) do_reset(2, s);
            drive(s, r, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
        end
        repeat (4) drive(0, 0, 0, 0);
        @(negedge clk);

        checks++;
        if (pq.size() != 0 || sq.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pulses %0d states pending required 0 0",
                     pq.size(), sq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
